// File: rtl/cond_unit_if.sv
// Execute-to-memory boundary bus for cond_unit.
// The master drives the execute-side instruction; the slave (cond_unit) returns the gated memory-stage view.
interface cond_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              valid_in;
    logic              stall;
    logic              flush;
    logic [3:0]        cond;
    logic [1:0]        alu_op;
    logic [3:0]        alu_flags;
    logic              flag_w;
    logic              reg_w_in;
    logic              mem_w_in;
    logic              pc_s_in;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] wa_in;
    logic              cond_ex;
    logic [3:0]        flags;
    logic              valid_out;
    logic              reg_w_out;
    logic              mem_w_out;
    logic              pc_s_out;
    logic [DATA_W-1:0] result_q;
    logic [REG_AW-1:0] wa_q;

    modport master (
        output valid_in, stall, flush, cond, alu_op, alu_flags, flag_w,
               reg_w_in, mem_w_in, pc_s_in, alu_result, wa_in,
        input  cond_ex, flags, valid_out, reg_w_out, mem_w_out, pc_s_out,
               result_q, wa_q
    );

    modport slave (
        input  valid_in, stall, flush, cond, alu_op, alu_flags, flag_w,
               reg_w_in, mem_w_in, pc_s_in, alu_result, wa_in,
        output cond_ex, flags, valid_out, reg_w_out, mem_w_out, pc_s_out,
               result_q, wa_q
    );
endinterface

// File: rtl/cond_unit.sv
// Condition unit: holds NZCV, evaluates the condition field and gates write enables at the EX/MEM boundary.
// Optional macro COND_PARTIAL_FLAGS_EN: logical ops (alu_op 1x) update only N and Z.
module cond_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    cond_unit_if.slave  bus
);
    logic [3:0]        r_flags;
    logic              r_valid;
    logic              r_regW;
    logic              r_memW;
    logic              r_pcS;
    logic [DATA_W-1:0] r_result;
    logic [REG_AW-1:0] r_wa;

    logic              w_condEx;
    logic              w_fire;
    logic [3:0]        w_flagsNext;
    logic              w_n, w_z, w_c, w_v;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Condition is evaluated against the committed flags only, never the ALU's in-flight flags.
    always_comb begin
        w_condEx = 1'b0;
        case (bus.cond)
            4'b0000: w_condEx = w_z;
            4'b0001: w_condEx = ~w_z;
            4'b0010: w_condEx = w_c;
            4'b0011: w_condEx = ~w_c;
            4'b0100: w_condEx = w_n;
            4'b0101: w_condEx = ~w_n;
            4'b0110: w_condEx = w_v;
            4'b0111: w_condEx = ~w_v;
            4'b1000: w_condEx = w_c & ~w_z;
            4'b1001: w_condEx = ~w_c | w_z;
            4'b1010: w_condEx = (w_n == w_v);
            4'b1011: w_condEx = (w_n != w_v);
            4'b1100: w_condEx = ~w_z & (w_n == w_v);
            4'b1101: w_condEx = w_z | (w_n != w_v);
            4'b1110: w_condEx = 1'b1;
            default: w_condEx = 1'b0;
        endcase
    end

    assign w_fire = bus.valid_in & w_condEx;

    always_comb begin
        w_flagsNext = bus.alu_flags;
`ifdef COND_PARTIAL_FLAGS_EN
        if (bus.alu_op[1]) begin
            w_flagsNext = {bus.alu_flags[3:2], r_flags[1:0]};
        end
`endif
    end

    // Flush beats stall; result/address are don't-care on flush so they simply hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags  <= 4'b0000;
            r_valid  <= 1'b0;
            r_regW   <= 1'b0;
            r_memW   <= 1'b0;
            r_pcS    <= 1'b0;
            r_result <= '0;
            r_wa     <= '0;
        end else if (bus.flush) begin
            r_valid  <= 1'b0;
            r_regW   <= 1'b0;
            r_memW   <= 1'b0;
            r_pcS    <= 1'b0;
        end else if (!bus.stall) begin
            r_valid  <= bus.valid_in;
            r_regW   <= w_fire & bus.reg_w_in;
            r_memW   <= w_fire & bus.mem_w_in;
            r_pcS    <= w_fire & bus.pc_s_in;
            r_result <= bus.alu_result;
            r_wa     <= bus.wa_in;
            if (w_fire && bus.flag_w) begin
                r_flags <= w_flagsNext;
            end
        end
    end

    assign bus.cond_ex   = w_condEx;
    assign bus.flags     = r_flags;
    assign bus.valid_out = r_valid;
    assign bus.reg_w_out = r_regW;
    assign bus.mem_w_out = r_memW;
    assign bus.pc_s_out  = r_pcS;
    assign bus.result_q  = r_result;
    assign bus.wa_q      = r_wa;
endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit with hand-computed expectations.
module tb_cond_unit;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    cond_unit_if #(.DATA_W(32), .REG_AW(4)) bus ();

    cond_unit #(.DATA_W(32), .REG_AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1ns after the edge, away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic fw,
                                 input logic [3:0] af, input logic [1:0] op,
                                 input logic rw, input logic mw, input logic ps,
                                 input logic [31:0] res, input logic [3:0] wa);
        bus.valid_in   = v;
        bus.cond       = c;
        bus.flag_w     = fw;
        bus.alu_flags  = af;
        bus.alu_op     = op;
        bus.reg_w_in   = rw;
        bus.mem_w_in   = mw;
        bus.pc_s_in    = ps;
        bus.alu_result = res;
        bus.wa_in      = wa;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n   = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        applyStimulus(0, 4'h0, 0, 4'h0, 2'b00, 0, 0, 0, 32'h0, 4'h0);
        step();
        step();
        checkOutput("rst_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("rst_valid", {31'h0, bus.valid_out}, 32'h0);
        checkOutput("rst_result", bus.result_q, 32'h0);
        reset_n = 1'b1;
        #1;

        // Load flags=1111 with a valid instruction, then freeze under stall and reset mid-cycle
        applyStimulus(1, 4'hE, 1, 4'hF, 2'b00, 1, 1, 1, 32'h1234, 4'h7);
        step();
        checkOutput("load_flags", {28'h0, bus.flags}, 32'hF);
        checkOutput("load_valid", {31'h0, bus.valid_out}, 32'h1);
        checkOutput("load_wa", {28'h0, bus.wa_q}, 32'h7);
        bus.stall = 1'b1;
        step();
        checkOutput("stall_valid", {31'h0, bus.valid_out}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("arst_valid", {31'h0, bus.valid_out}, 32'h0);
        checkOutput("arst_en", {29'h0, bus.reg_w_out, bus.mem_w_out, bus.pc_s_out}, 32'h0);
        reset_n   = 1'b1;
        bus.stall = 1'b0;
        step();

        // SUBS r1==r1 followed immediately by EQ then NE
        applyStimulus(1, 4'hE, 1, 4'h6, 2'b01, 0, 0, 0, 32'h0, 4'h1);
        step();
        checkOutput("subs_flags", {28'h0, bus.flags}, 32'h6);
        applyStimulus(1, 4'h0, 0, 4'h0, 2'b00, 1, 0, 0, 32'hDEAD, 4'h3);
        #1;
        checkOutput("eq_condex", {31'h0, bus.cond_ex}, 32'h1);
        step();
        checkOutput("eq_regw", {31'h0, bus.reg_w_out}, 32'h1);
        checkOutput("eq_result", bus.result_q, 32'hDEAD);
        checkOutput("eq_wa", {28'h0, bus.wa_q}, 32'h3);
        applyStimulus(1, 4'h1, 0, 4'h0, 2'b00, 1, 0, 0, 32'hBEEF, 4'h3);
        #1;
        checkOutput("ne_condex", {31'h0, bus.cond_ex}, 32'h0);
        step();
        checkOutput("ne_regw", {31'h0, bus.reg_w_out}, 32'h0);
        checkOutput("ne_valid", {31'h0, bus.valid_out}, 32'h1);

        // Failed-condition flag setter must not write flags
        applyStimulus(1, 4'hE, 1, 4'h0, 2'b00, 0, 0, 0, 32'h0, 4'h0);
        step();
        applyStimulus(1, 4'h0, 1, 4'h8, 2'b00, 1, 0, 0, 32'h0, 4'h2);
        step();
        checkOutput("fail_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("fail_regw", {31'h0, bus.reg_w_out}, 32'h0);
        checkOutput("fail_valid", {31'h0, bus.valid_out}, 32'h1);

        // Signed compares with N=V, then N!=V
        applyStimulus(1, 4'hE, 1, 4'h9, 2'b01, 0, 0, 0, 32'h0, 4'h0);
        step();
        bus.cond = 4'hA; #1;
        checkOutput("ge_1001", {31'h0, bus.cond_ex}, 32'h1);
        bus.cond = 4'hB; #1;
        checkOutput("lt_1001", {31'h0, bus.cond_ex}, 32'h0);
        bus.cond = 4'hC; #1;
        checkOutput("gt_1001", {31'h0, bus.cond_ex}, 32'h1);
        applyStimulus(1, 4'hE, 1, 4'hD, 2'b01, 0, 0, 0, 32'h0, 4'h0);
        step();
        bus.cond = 4'hC; #1;
        checkOutput("gt_1101", {31'h0, bus.cond_ex}, 32'h0);
        bus.cond = 4'hD; #1;
        checkOutput("le_1101", {31'h0, bus.cond_ex}, 32'h1);
        bus.cond = 4'h8; #1;
        checkOutput("hi_1101", {31'h0, bus.cond_ex}, 32'h0);
        bus.cond = 4'h9; #1;
        checkOutput("ls_1101", {31'h0, bus.cond_ex}, 32'h1);
        bus.cond = 4'hF; #1;
        checkOutput("nv_1101", {31'h0, bus.cond_ex}, 32'h0);

        // Invalid instruction never writes flags or enables
        applyStimulus(0, 4'hE, 1, 4'h0, 2'b00, 1, 1, 1, 32'h0, 4'h0);
        step();
        checkOutput("inv_flags", {28'h0, bus.flags}, 32'hD);
        checkOutput("inv_en", {29'h0, bus.reg_w_out, bus.mem_w_out, bus.pc_s_out}, 32'h0);

        // Stall freezes everything for three cycles, then stall+flush kills
        applyStimulus(1, 4'hE, 0, 4'h0, 2'b00, 0, 1, 0, 32'hAA, 4'h5);
        step();
        checkOutput("pre_memw", {31'h0, bus.mem_w_out}, 32'h1);
        bus.stall = 1'b1;
        applyStimulus(1, 4'hE, 1, 4'h2, 2'b00, 1, 0, 1, 32'hBB, 4'h6);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_flags", {28'h0, bus.flags}, 32'hD);
            checkOutput("stall_memw", {31'h0, bus.mem_w_out}, 32'h1);
            checkOutput("stall_res", bus.result_q, 32'hAA);
        end
        bus.flush = 1'b1;
        step();
        checkOutput("flush_valid", {31'h0, bus.valid_out}, 32'h0);
        checkOutput("flush_en", {29'h0, bus.reg_w_out, bus.mem_w_out, bus.pc_s_out}, 32'h0);
        checkOutput("flush_flags", {28'h0, bus.flags}, 32'hD);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        step();
        checkOutput("resume_pcs", {31'h0, bus.pc_s_out}, 32'h1);
        checkOutput("resume_flags", {28'h0, bus.flags}, 32'h2);

        // Logical flag-setter: partial vs full NZCV write
        applyStimulus(1, 4'hE, 1, 4'h3, 2'b00, 0, 0, 0, 32'h0, 4'h0);
        step();
        checkOutput("pre_ands", {28'h0, bus.flags}, 32'h3);
        applyStimulus(1, 4'hE, 1, 4'h4, 2'b10, 1, 0, 0, 32'h0, 4'h0);
        step();
`ifdef COND_PARTIAL_FLAGS_EN
        checkOutput("ands_flags", {28'h0, bus.flags}, 32'h7);
`else
        checkOutput("ands_flags", {28'h0, bus.flags}, 32'h4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
